// File: rtl/alu_arbiter.sv
// alu_arbiter -- lets two requesters share one combinational ALU.
// A request is granted combinationally when the single-entry response slot
// can take a new result; the ALU output is captured into that slot on the
// next rising edge, tagged with the index of the requester that issued it.
// Conflicts are settled round-robin by default.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN -- requester 0 always wins a
// conflict and the round-robin history register is not built.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_control,
   output logic [WIDTH-1:0] alu_src1,
   output logic [WIDTH-1:0] alu_src2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slotState_t;

   slotState_t slotState;
   logic       xferAllowed;
   logic       pick1;
   logic       grant0;
   logic       grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic       lastGrant;
`endif

   // The slot can accept a new result when it is empty or being drained
   // this cycle; nothing is granted while reset is asserted.
   always_comb begin
      xferAllowed = !rst && ((slotState == SLOT_EMPTY) || rsp_ready);
   end

   // Pick which requester would win if the slot can take a result: a lone
   // requester always wins, a conflict goes to the one not served last
   // (or to requester 0 when fixed priority is built).
   always_comb begin
      pick1 = 1'b0;
      if (req1_valid && !req0_valid) begin
         pick1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         pick1 = 1'b0;
`else
         pick1 = !lastGrant;
`endif
      end
   end

   // Grants are one-hot or zero, so the ALU mux below never sees two sources.
   always_comb begin
      grant0 = xferAllowed && req0_valid && !pick1;
      grant1 = xferAllowed && req1_valid && pick1;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp_valid  = (slotState == SLOT_FULL);

   // Steer the granted requester's operation onto the shared ALU; drive
   // zeros when nobody is granted so the ALU sees a quiet, known input.
   always_comb begin
      alu_control = 4'b0000;
      alu_src1    = '0;
      alu_src2    = '0;
      if (grant0) begin
         alu_control = req0_op;
         alu_src1    = req0_a;
         alu_src2    = req0_b;
      end else if (grant1) begin
         alu_control = req1_op;
         alu_src1    = req1_a;
         alu_src2    = req1_b;
      end
   end

   // Response slot: capture the ALU output on a grant (overwriting a slot
   // being drained in the same cycle), empty it on a drain with no new
   // work, otherwise hold everything stable. Reset discards any pending
   // response and makes requester 0 the first conflict winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slotState  <= SLOT_EMPTY;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         lastGrant  <= 1'b1;
`endif
      end else if (grant0 || grant1) begin
         slotState  <= SLOT_FULL;
         rsp_id     <= grant1;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
         lastGrant  <= grant1;
`endif
      end else if ((slotState == SLOT_FULL) && rsp_ready) begin
         slotState  <= SLOT_EMPTY;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- self-checking bench for alu_arbiter.
// Supplies a behavioural shared ALU, runs directed scenarios followed by a
// randomized phase, and compares the DUT every cycle against a reference
// model of the arbitration and response-slot rules.
// Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_arbiter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0;
   logic         req0_ready;
   logic [3:0]   req0_op = 4'h0;
   logic [W-1:0] req0_a = '0;
   logic [W-1:0] req0_b = '0;
   logic         req1_valid = 1'b0;
   logic         req1_ready;
   logic [3:0]   req1_op = 4'h0;
   logic [W-1:0] req1_a = '0;
   logic [W-1:0] req1_b = '0;
   logic [3:0]   alu_control;
   logic [W-1:0] alu_src1;
   logic [W-1:0] alu_src2;
   logic [W-1:0] alu_result;
   logic         alu_zero;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic         rsp_id;
   logic [W-1:0] rsp_result;
   logic         rsp_zero;

   int total = 0;
   int bad   = 0;

   // Reference model: current visible slot (m*) and the slot expected after
   // the coming clock edge (n*); mLast is the index served most recently.
   logic         mValid, mId, mZero, mLast;
   logic [W-1:0] mResult;
   logic         nValid, nId, nZero, nLast;
   logic [W-1:0] nResult;
   int           lastWinner;

   // Randomized-phase pending requests, held until accepted.
   logic         p0v, p1v;
   logic [3:0]   p0op, p1op;
   logic [W-1:0] p0a, p0b, p1a, p1b;
   logic         rr;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op     (req0_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op     (req1_op),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .alu_control (alu_control),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Behavioural ALU: add, sub, and, or, xor, slt, sll, sltu, srl; any
   // other code yields zero.
   function automatic logic [W-1:0] aluRef(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         4'h0:    r = a + b;
         4'h1:    r = a - b;
         4'h2:    r = a & b;
         4'h3:    r = a | b;
         4'h4:    r = a ^ b;
         4'h5:    r = ($signed(a) < $signed(b)) ? W'(1) : '0;
         4'h6:    r = a << b[4:0];
         4'h7:    r = (a < b) ? W'(1) : '0;
         4'h8:    r = a >> b[4:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   assign alu_result = aluRef(alu_control, alu_src1, alu_src2);
   assign alu_zero   = (alu_result == '0);

   function automatic logic [W-1:0] pickOperand();
      logic [W-1:0] v;
      case ($urandom_range(0, 3))
         0:       v = '0;
         1:       v = '1;
         2:       v = W'($urandom_range(0, 3));
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, check the
   // combinational grant, ALU steering and visible slot before the next
   // edge, then work out what the slot should hold after that edge.
   task automatic applyStimulus(input logic v0, input logic [3:0] o0,
                                input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic v1, input logic [3:0] o1,
                                input logic [W-1:0] a1, input logic [W-1:0] b1,
                                input logic ready);
      int           winner;
      int           preferred;
      logic         allowed;
      logic [3:0]   expOp;
      logic [W-1:0] expA, expB;
      @(posedge clk);
      #1;
      mValid = nValid; mId = nId; mResult = nResult; mZero = nZero; mLast = nLast;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      rsp_ready  = ready;
      #3;
      allowed = !mValid || ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
      preferred = 0;
`else
      preferred = (mLast == 1'b1) ? 0 : 1;
`endif
      if (v0 && v1)  winner = preferred;
      else if (v0)   winner = 0;
      else if (v1)   winner = 1;
      else           winner = -1;
      if (!allowed) winner = -1;
      expOp = 4'h0; expA = '0; expB = '0;
      if (winner == 0) begin expOp = o0; expA = a0; expB = b0; end
      if (winner == 1) begin expOp = o1; expA = a1; expB = b1; end
      checkBit("ready0", req0_ready, winner == 0);
      checkBit("ready1", req1_ready, winner == 1);
      checkOutput("aluControl", W'(alu_control), W'(expOp));
      checkOutput("aluSrc1", alu_src1, expA);
      checkOutput("aluSrc2", alu_src2, expB);
      checkBit("rspValid", rsp_valid, mValid);
      if (mValid) begin
         checkBit("rspId", rsp_id, mId);
         checkOutput("rspResult", rsp_result, mResult);
         checkBit("rspZero", rsp_zero, mZero);
      end
      if (winner >= 0) begin
         nValid  = 1'b1;
         nId     = (winner == 1);
         nResult = (winner == 1) ? aluRef(o1, a1, b1) : aluRef(o0, a0, b0);
         nZero   = (nResult == '0);
         nLast   = (winner == 1);
      end else if (mValid && ready) begin
         nValid  = 1'b0;
      end
      lastWinner = winner;
   endtask

   task automatic idleCycle(input logic ready);
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0, ready);
   endtask

   // Asynchronous reset pulse with both requesters asserting work: the slot
   // must clear before any clock edge and nothing may be granted while held.
   task automatic doReset();
      req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'hA5A5_0001; req0_b = 32'h55;
      req1_valid = 1'b1; req1_op = 4'h0; req1_a = 32'h1234_5678; req1_b = 32'h9;
      rsp_ready  = 1'b1;
      rst = 1'b1;
      #1;
      checkBit("rstValid", rsp_valid, 1'b0);
      checkBit("rstId", rsp_id, 1'b0);
      checkOutput("rstResult", rsp_result, '0);
      checkBit("rstZero", rsp_zero, 1'b0);
      checkBit("rstReady0", req0_ready, 1'b0);
      checkBit("rstReady1", req1_ready, 1'b0);
      checkOutput("rstAluControl", W'(alu_control), '0);
      checkOutput("rstAluSrc1", alu_src1, '0);
      checkOutput("rstAluSrc2", alu_src2, '0);
      @(posedge clk);
      #2;
      checkBit("rstHoldValid", rsp_valid, 1'b0);
      checkBit("rstHoldReady0", req0_ready, 1'b0);
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      mValid = 1'b0; mId = 1'b0; mResult = '0; mZero = 1'b0; mLast = 1'b1;
      nValid = 1'b0; nId = 1'b0; nResult = '0; nZero = 1'b0; nLast = 1'b1;
      lastWinner = -1;
   endtask

   // Directed scenarios first, then randomized traffic against the model.
   initial begin
      logic expId;
      $display("[TB] reset and directed scenarios");
      doReset();

      // Single requester add: 5 + 7 appears one cycle later.
      applyStimulus(1'b1, 4'h0, 32'd5, 32'd7, 1'b0, 4'h0, '0, '0, 1'b1);
      checkBit("addReady0", req0_ready, 1'b1);
      idleCycle(1'b1);
      checkBit("addValid", rsp_valid, 1'b1);
      checkBit("addId", rsp_id, 1'b0);
      checkOutput("addResult", rsp_result, 32'd12);
      checkBit("addZero", rsp_zero, 1'b0);

      // Conflict after reset: requester 0 first, then requester 1.
      doReset();
      applyStimulus(1'b1, 4'h1, 32'd9, 32'd9, 1'b1, 4'h3, 32'hF0, 32'h0F, 1'b1);
      checkBit("conflictReady0", req0_ready, 1'b1);
      applyStimulus(1'b1, 4'h0, 32'd5, 32'd7, 1'b1, 4'h3, 32'hF0, 32'h0F, 1'b1);
      checkBit("rrReady1", req1_ready, 1'b1);
      checkBit("conflictId0", rsp_id, 1'b0);
      checkOutput("conflictResult0", rsp_result, 32'd0);
      checkBit("conflictZero0", rsp_zero, 1'b1);

      // Back-pressure: slot full and not drained, both requesters waiting.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'h0, 32'd5, 32'd7, 1'b1, 4'h4, 32'h3, 32'h1, 1'b0);
         checkBit("stallReady0", req0_ready, 1'b0);
         checkBit("stallReady1", req1_ready, 1'b0);
         checkBit("stallValid", rsp_valid, 1'b1);
         checkBit("stallId", rsp_id, 1'b1);
         checkOutput("stallResult", rsp_result, 32'hFF);
         checkBit("stallZero", rsp_zero, 1'b0);
      end
      applyStimulus(1'b1, 4'h0, 32'd5, 32'd7, 1'b1, 4'h4, 32'h3, 32'h1, 1'b1);
      checkBit("releaseReady0", req0_ready, 1'b1);
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 4'h4, 32'h3, 32'h1, 1'b1);
      checkBit("releaseId", rsp_id, 1'b0);
      checkOutput("releaseResult", rsp_result, 32'd12);

      // Signed and unsigned compares plus an unsupported code on requester 1.
      idleCycle(1'b1);
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 4'h5, 32'hFFFF_FFFF, 32'd1, 1'b1);
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 4'h7, 32'hFFFF_FFFF, 32'd1, 1'b1);
      checkBit("sltId", rsp_id, 1'b1);
      checkOutput("sltResult", rsp_result, 32'd1);
      checkBit("sltZero", rsp_zero, 1'b0);
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd1, 1'b1);
      checkOutput("sltuResult", rsp_result, 32'd0);
      checkBit("sltuZero", rsp_zero, 1'b1);
      checkOutput("unsupAluControl", W'(alu_control), 32'hF);
      idleCycle(1'b0);
      checkBit("unsupValid", rsp_valid, 1'b1);
      checkOutput("unsupResult", rsp_result, 32'd0);
      checkBit("unsupZero", rsp_zero, 1'b1);

      // Reset mid-cycle while a response is still waiting to be taken.
      applyStimulus(1'b1, 4'h2, 32'hF0F0, 32'hFF00, 1'b0, 4'h0, '0, '0, 1'b1);
      idleCycle(1'b0);
      checkBit("preRstValid", rsp_valid, 1'b1);
      doReset();
      idleCycle(1'b0);
      checkBit("postRstValid", rsp_valid, 1'b0);
      idleCycle(1'b1);
      checkBit("postRstValid2", rsp_valid, 1'b0);

      // Sustained conflict: id sequence depends on the arbitration policy.
      doReset();
      for (int i = 0; i < 5; i++) begin
         if (i < 4)
            applyStimulus(1'b1, 4'h0, W'(i), 32'd100, 1'b1, 4'h0, W'(i), 32'd200, 1'b1);
         else
            idleCycle(1'b1);
         if (i > 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            expId = 1'b0;
`else
            expId = ((i - 1) % 2) == 1;
`endif
            checkBit("seqId", rsp_id, expId);
            checkOutput("seqResult", rsp_result, W'(i - 1) + (expId ? 32'd200 : 32'd100));
         end
      end

      $display("[TB] randomized traffic");
      doReset();
      p0v = 1'b0; p1v = 1'b0;
      p0op = 4'h0; p1op = 4'h0;
      p0a = '0; p0b = '0; p1a = '0; p1b = '0;
      for (int i = 0; i < 600; i++) begin
         if (!p0v || lastWinner == 0) begin
            p0v  = ($urandom_range(0, 3) != 0);
            p0op = 4'($urandom_range(0, 15));
            p0a  = pickOperand();
            p0b  = pickOperand();
         end
         if (!p1v || lastWinner == 1) begin
            p1v  = ($urandom_range(0, 3) != 0);
            p1op = 4'($urandom_range(0, 15));
            p1a  = pickOperand();
            p1b  = pickOperand();
         end
         rr = ($urandom_range(0, 3) != 0);
         applyStimulus(p0v, p0op, p0a, p0b, p1v, p1op, p1a, p1b, rr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
